// File: rtl/alu_sequencer_if.sv
// Command, ALU and result bundle between the sequencer, its command source,
// the shared ALU and the result consumer.
interface alu_sequencer_if #(parameter int Bits = 5);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [Bits-1:0] cmd_data;
  logic [Bits-1:0] alu_a;
  logic [Bits-1:0] alu_b;
  logic [1:0]      alu_ctrl;
  logic [Bits-1:0] alu_result;
  logic [3:0]      alu_flags;
  logic            res_valid;
  logic            res_ready;
  logic [Bits-1:0] res_data;
  logic [3:0]      res_flags;
  logic            res_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_result, alu_flags, res_ready,
    output cmd_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_flags, res_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_result, alu_flags, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_ctrl, res_valid, res_data, res_flags, res_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator-based command sequencer driving a shared combinational ALU;
// MUL is a fixed-latency shift-and-add loop reusing the ALU adder.
module alu_sequencer #(
  parameter int Bits = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  localparam int CW = $clog2(Bits + 1);
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [Bits-1:0] opnd_q, opnd_d;
  logic [Bits-1:0] acc_q, acc_d;
  logic [Bits-1:0] prod_q, prod_d;
  logic [Bits-1:0] mcand_q, mcand_d;
  logic [Bits-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [Bits-1:0] res_data_q, res_data_d;
  logic [3:0]      res_flags_q, res_flags_d;
  logic            res_err_q, res_err_d;

  logic [Bits-1:0] alu_a, alu_b, prod_nxt;
  logic [1:0]      alu_ctrl;

  // Flags for values that never went through the ALU: N and Z only.
  function automatic logic [3:0] val_flags(input logic [Bits-1:0] v);
    return {v[Bits-1], v == '0, 2'b00};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_err_q   <= res_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_err_d   = res_err_q;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = 2'b00;
    prod_nxt    = prod_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          opnd_d    = bus.cmd_data;
          res_err_d = 1'b0;
          if (bus.cmd_op == OP_MUL) begin
            prod_d   = '0;
            mcand_d  = acc_q;
            mplier_d = bus.cmd_data;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            state_d  = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        alu_a    = acc_q;
        alu_b    = opnd_q;
        alu_ctrl = 2'(op_q - 3'd1);
        state_d  = S_DONE;
        case (op_q)
          OP_LOAD: begin
            acc_d       = opnd_q;
            res_data_d  = opnd_q;
            res_flags_d = val_flags(opnd_q);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            acc_d       = bus.alu_result;
            res_data_d  = bus.alu_result;
            res_flags_d = bus.alu_flags;
          end
          default: begin
            res_err_d   = 1'b1;
            res_data_d  = acc_q;
            res_flags_d = val_flags(acc_q);
          end
        endcase
      end

      S_MUL: begin
        // Every iteration spends a full cycle so MUL latency is constant.
        alu_a    = prod_q;
        alu_b    = mcand_q;
        prod_nxt = mplier_q[0] ? bus.alu_result : prod_q;
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(Bits - 1)) begin
          acc_d       = prod_nxt;
          res_data_d  = prod_nxt;
          res_flags_d = val_flags(prod_nxt);
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_err   = res_err_q;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_ctrl  = alu_ctrl;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the ALU port.
module tb_alu_sequencer;
  localparam int B = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if #(.Bits(B)) bus();
  alu_sequencer #(.Bits(B)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ALU model: C is the carry out (SUB uses a + ~b + 1), V is signed overflow.
  logic [B:0]   sum;
  logic [B-1:0] a, b, r;
  logic         c, v;
  always_comb begin
    a = bus.alu_a;
    b = bus.alu_b;
    sum = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (bus.alu_ctrl)
      2'b00: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[B-1:0];
        c = sum[B];
        v = (a[B-1] == b[B-1]) && (r[B-1] != a[B-1]);
      end
      2'b01: begin
        sum = {1'b0, a} + {1'b0, ~b} + (B+1)'(1);
        r = sum[B-1:0];
        c = sum[B];
        v = (a[B-1] != b[B-1]) && (r[B-1] != a[B-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
  end
  assign bus.alu_result = r;
  assign bus.alu_flags  = {r[B-1], r == '0, c, v};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input string name, input logic [2:0] op, input logic [B-1:0] d,
                         input logic [B-1:0] ed, input logic [3:0] ef, input logic ee,
                         input int lat, input bit consume);
    int n;
    @(negedge clk);
    chk({name, " cmd_ready"}, 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " res_data"}, 32'(bus.res_data), 32'(ed));
    chk({name, " res_flags"}, 32'(bus.res_flags), 32'(ef));
    chk({name, " res_err"}, 32'(bus.res_err), 32'(ee));
    if (consume) begin
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk({name, " res_valid drop"}, 32'(bus.res_valid), 0);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [B-1:0] d;
    logic [B-1:0] ed;
    logic [3:0]   ef;
    logic         ee;
    int           lat;
  } vec_t;

  vec_t vt[20];

  initial begin
    vt[0]  = '{3'd0, 5'd7,  5'd7,  4'b0000, 1'b0, 1};
    vt[1]  = '{3'd1, 5'd12, 5'd19, 4'b1001, 1'b0, 1};
    vt[2]  = '{3'd2, 5'd19, 5'd0,  4'b0110, 1'b0, 1};
    vt[3]  = '{3'd0, 5'd6,  5'd6,  4'b0000, 1'b0, 1};
    vt[4]  = '{3'd5, 5'd5,  5'd30, 4'b1000, 1'b0, 5};
    vt[5]  = '{3'd0, 5'd6,  5'd6,  4'b0000, 1'b0, 1};
    vt[6]  = '{3'd5, 5'd7,  5'd10, 4'b0000, 1'b0, 5};
    vt[7]  = '{3'd0, 5'd9,  5'd9,  4'b0000, 1'b0, 1};
    vt[8]  = '{3'd5, 5'd0,  5'd0,  4'b0100, 1'b0, 5};
    vt[9]  = '{3'd0, 5'd22, 5'd22, 4'b1000, 1'b0, 1};
    vt[10] = '{3'd3, 5'd13, 5'd4,  4'b0000, 1'b0, 1};
    vt[11] = '{3'd4, 5'd9,  5'd13, 4'b0000, 1'b0, 1};
    vt[12] = '{3'd0, 5'd3,  5'd3,  4'b0000, 1'b0, 1};
    vt[13] = '{3'd6, 5'd5,  5'd3,  4'b0000, 1'b1, 1};
    vt[14] = '{3'd0, 5'd16, 5'd16, 4'b1000, 1'b0, 1};
    vt[15] = '{3'd2, 5'd17, 5'd31, 4'b1000, 1'b0, 1};
    vt[16] = '{3'd1, 5'd1,  5'd0,  4'b0110, 1'b0, 1};
    vt[17] = '{3'd7, 5'd2,  5'd0,  4'b0100, 1'b1, 1};
    vt[18] = '{3'd0, 5'd31, 5'd31, 4'b1000, 1'b0, 1};
    vt[19] = '{3'd5, 5'd31, 5'd1,  4'b0000, 1'b0, 5};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset cmd_ready", 32'(bus.cmd_ready), 1);
    chk("reset res_valid", 32'(bus.res_valid), 0);
    chk("reset res_data", 32'(bus.res_data), 0);
    chk("reset res_flags", 32'(bus.res_flags), 0);
    chk("reset res_err", 32'(bus.res_err), 0);
    chk("reset alu_a", 32'(bus.alu_a), 0);
    chk("reset alu_ctrl", 32'(bus.alu_ctrl), 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      run_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].d, vt[i].ed, vt[i].ef, vt[i].ee,
              vt[i].lat, 1'b1);

    // Back-pressure: result held while ignored commands toggle.
    run_cmd("bp load", 3'd0, 5'd2, 5'd2, 4'b0000, 1'b0, 1, 1'b1);
    run_cmd("bp add", 3'd1, 5'd3, 5'd5, 4'b0000, 1'b0, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.cmd_valid = (i % 2 == 0);
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 5'd31;
      chk($sformatf("bp%0d res_data", i), 32'(bus.res_data), 5);
      chk($sformatf("bp%0d res_flags", i), 32'(bus.res_flags), 0);
      chk($sformatf("bp%0d cmd_ready", i), 32'(bus.cmd_ready), 0);
      chk($sformatf("bp%0d res_valid", i), 32'(bus.res_valid), 1);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    run_cmd("bp acc kept", 3'd1, 5'd0, 5'd5, 4'b0000, 1'b0, 1, 1'b1);

    // Reset in the middle of a MUL.
    run_cmd("rst load", 3'd0, 5'd6, 5'd6, 4'b0000, 1'b0, 1, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_data  = 5'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid-mul rst res_valid", 32'(bus.res_valid), 0);
    chk("mid-mul rst cmd_ready", 32'(bus.cmd_ready), 1);
    chk("mid-mul rst res_data", 32'(bus.res_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst res_valid", 32'(bus.res_valid), 0);
    chk("post rst cmd_ready", 32'(bus.cmd_ready), 1);
    run_cmd("post rst acc zero", 3'd1, 5'd3, 5'd3, 4'b0000, 1'b0, 1, 1'b1);
    run_cmd("post rst load", 3'd0, 5'd1, 5'd1, 4'b0000, 1'b0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
